// File: rtl/dcm_reset_sequencer_if.sv
// Signal bundle between the DCM reset sequencer (master) and the DCM plus its reset consumers (slave).
interface dcm_reset_sequencer_if #(
    parameter int unsigned N_DOMAINS   = 3,
    parameter int unsigned MAX_RETRIES = 3
);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    logic                 dcm_locked;
    logic                 dcm_rst_o;
    logic [N_DOMAINS-1:0] domain_rstn_o;
    logic                 sys_ready_o;
    logic                 fault_o;
    logic [RETRY_W-1:0]   retry_cnt_o;
    logic [7:0]           lock_loss_cnt_o;

    modport master (
        input  dcm_locked,
        output dcm_rst_o,
        output domain_rstn_o,
        output sys_ready_o,
        output fault_o,
        output retry_cnt_o,
        output lock_loss_cnt_o
    );

    modport slave (
        output dcm_locked,
        input  dcm_rst_o,
        input  domain_rstn_o,
        input  sys_ready_o,
        input  fault_o,
        input  retry_cnt_o,
        input  lock_loss_cnt_o
    );
endinterface

// File: rtl/dcm_reset_sequencer.sv
// DCM lock handshake initiator: pulses DCM reset, filters lock, releases domain resets in a staggered order.
module dcm_reset_sequencer #(
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned LOCK_TIMEOUT   = 12000,
    parameter int unsigned STABLE_CYCLES  = 64,
    parameter int unsigned N_DOMAINS      = 3,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                   clk_i,
    input  logic                   internal_rst_En,
    dcm_reset_sequencer_if.master  bus
);
    localparam int unsigned REL_LIMIT = STAGGER_CYCLES * (N_DOMAINS - 1);
    localparam int unsigned PLS_W     = $clog2(PULSE_CYCLES) + 1;
    localparam int unsigned TMR_W     = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned STB_W     = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned REL_W     = $clog2(REL_LIMIT + 1) + 1;
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [PLS_W-1:0]   PULSE_LAST = PLS_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TMR_MAX    = TMR_W'(LOCK_TIMEOUT);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(STABLE_CYCLES - 1);
    localparam logic [REL_W-1:0]   REL_LAST   = REL_W'(REL_LIMIT);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PULSE,
        ST_WAIT_LOCK,
        ST_FILTER,
        ST_RELEASE,
        ST_RUN,
        ST_FAULT
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [PLS_W-1:0]     pulse_q, pulse_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [STB_W-1:0]     stable_q, stable_d;
    logic [REL_W-1:0]     rel_q, rel_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [7:0]           loss_q, loss_d;
    logic                 dcm_rst_q, dcm_rst_d;
    logic [N_DOMAINS-1:0] dom_q, dom_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;

    logic                 lock_s;
    logic                 timeout;
    logic                 lost;
    logic [RETRY_W-1:0]   retry_inc;

    assign lock_s    = sync_q[1];
    assign timeout   = (timer_q == TMR_MAX);
    assign retry_inc = retry_q + RETRY_W'(1);

    always_ff @(posedge clk_i or posedge internal_rst_En) begin
        if (internal_rst_En) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.dcm_locked};
        end
    end

    always_ff @(posedge clk_i or posedge internal_rst_En) begin
        if (internal_rst_En) begin
            state_q   <= ST_PULSE;
            pulse_q   <= '0;
            timer_q   <= '0;
            stable_q  <= '0;
            rel_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            dcm_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            rel_q     <= rel_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            dcm_rst_q <= dcm_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    // Per-state counters default to zero so each is cleared on entry to the state that uses it.
    always_comb begin
        state_d  = state_q;
        pulse_d  = '0;
        timer_d  = '0;
        stable_d = '0;
        rel_d    = '0;
        retry_d  = retry_q;
        loss_d   = loss_q;
        lost     = 1'b0;

        unique case (state_q)
            ST_PULSE: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    pulse_d = pulse_q + PLS_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (timeout) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_PULSE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (lock_s) begin
                        state_d = ST_FILTER;
                    end
                end
            end
            ST_FILTER: begin
                if (timeout) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_PULSE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (stable_q == STB_LAST) begin
                        state_d = ST_RELEASE;
                    end else begin
                        stable_d = stable_q + STB_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (rel_q == REL_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else begin
                    rel_d = rel_q + REL_W'(1);
                end
            end
            ST_RUN: begin
                retry_d = '0;
                if (!lock_s) begin
                    lost = 1'b1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_PULSE;
            end
        endcase

        if (lost) begin
            state_d = ST_PULSE;
            if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end
    end

    // Outputs are registered from the next state so they switch with the state and never glitch.
    always_comb begin
        dcm_rst_d = (state_d == ST_PULSE) || (state_d == ST_FAULT);
        fault_d   = (state_d == ST_FAULT);
        ready_d   = (state_d == ST_RUN);
        dom_d     = '0;
        for (int unsigned k = 0; k < N_DOMAINS; k++) begin
            dom_d[k] = (state_d == ST_RUN) ||
                       ((state_d == ST_RELEASE) && (rel_d >= REL_W'(STAGGER_CYCLES * k)));
        end
    end

    assign bus.dcm_rst_o       = dcm_rst_q;
    assign bus.domain_rstn_o   = dom_q;
    assign bus.sys_ready_o     = ready_q;
    assign bus.fault_o         = fault_q;
    assign bus.retry_cnt_o     = retry_q;
    assign bus.lock_loss_cnt_o = loss_q;
endmodule
